// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor, Y = A - B - BI, LSB first.
// One full-subtractor cell; eight RUN cycles per operation.
module serial_subtractor (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       BI,
  output logic       busy,
  output logic       done,
  output logic [7:0] Y,
  output logic       C,
  output logic       V,
  output logic       Z,
  output logic       N
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t     state_q;
  logic [7:0] a_sh_q;
  logic [7:0] b_sh_q;
  logic [7:0] y_sh_q;
  logic       borrow_q;
  logic [2:0] cnt_q;
  logic       a7_q;
  logic       b7_q;

  logic       diff_d;
  logic       borrow_d;
  logic [7:0] y_d;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff_d   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_d = (~a_sh_q[0] & b_sh_q[0])
             | (~a_sh_q[0] & borrow_q)
             | (b_sh_q[0] & borrow_q);
    y_d      = {diff_d, y_sh_q[7:1]};
  end

  // Control FSM, datapath shifting and registered results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      y_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a7_q     <= 1'b0;
      b7_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y        <= '0;
      C        <= 1'b0;
      V        <= 1'b0;
      Z        <= 1'b0;
      N        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            borrow_q <= BI;
            a7_q     <= A[7];
            b7_q     <= B[7];
            y_sh_q   <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= {1'b0, a_sh_q[7:1]};
          b_sh_q   <= {1'b0, b_sh_q[7:1]};
          borrow_q <= borrow_d;
          y_sh_q   <= y_d;
          cnt_q    <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            Y       <= y_d;
            C       <= borrow_d;
            V       <= (a7_q ^ b7_q) & (y_d[7] ^ a7_q);
            Z       <= (y_d == 8'h00);
            N       <= y_d[7];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model
// compared every cycle, plus directed literal expectations.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       BI = 1'b0;
  logic       busy, done, C, V, Z, N;
  logic [7:0] Y;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  serial_subtractor dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .A(A), .B(B), .BI(BI),
    .busy(busy), .done(done), .Y(Y),
    .C(C), .V(V), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: result appears 8 edges after acceptance.
  logic       m_busy = 0, m_done = 0;
  logic [7:0] m_y = 0;
  logic       m_c = 0, m_v = 0, m_z = 0, m_n = 0;
  int         m_left = 0;
  logic [7:0] pa, pb;
  logic       pbi;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_y = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_y = 8'((int'(pa) - int'(pb) - int'(pbi)) & 255);
          m_c = int'(pa) < int'(pb) + int'(pbi);
          m_v = (pa[7] != pb[7]) && (m_y[7] != pa[7]);
          m_z = (m_y == 0);
          m_n = m_y[7];
          m_done = 1;
          m_busy = 0;
        end
      end else if (start) begin
        pa = A; pb = B; pbi = BI;
        m_busy = 1;
        m_left = 8;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en)
      chk("model", {19'd0, busy, done, Y, C, V, Z, N},
          {19'd0, m_busy, m_done, m_y, m_c, m_v, m_z, m_n});
  end

  task automatic wait_done(output int nb, output bit seen);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string nm,
                       input logic [7:0] a, b,
                       input logic bi,
                       input logic [7:0] ey,
                       input logic ec, ev, ez, en);
    int nb;
    bit seen;
    A = a; B = b; BI = bi; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(nb, seen);
    chk({nm, "_done"}, 32'(seen), 32'd1);
    chk({nm, "_busycyc"}, 32'(nb), 32'd8);
    chk({nm, "_busy0"}, 32'(busy), 32'd0);
    chk({nm, "_Y"}, 32'(Y), 32'(ey));
    chk({nm, "_CVZN"}, {28'd0, C, V, Z, N},
        {28'd0, ec, ev, ez, en});
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nb;
    bit seen;
    bit any_done;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {19'd0, busy, done, Y, C, V, Z, N}, 32'd0);
    cmp_en = 1;
    reset_n = 1;
    @(negedge clk);

    do_op("sub1", 8'h50, 8'h30, 0, 8'h20, 0, 0, 0, 0);
    do_op("sub2", 8'h30, 8'h50, 0, 8'hE0, 1, 0, 0, 1);
    do_op("ov1",  8'h80, 8'h01, 0, 8'h7F, 0, 1, 0, 0);
    do_op("ov2",  8'h7F, 8'hFF, 0, 8'h80, 1, 1, 0, 1);
    do_op("bi1",  8'h00, 8'h00, 1, 8'hFF, 1, 0, 0, 1);
    do_op("zero", 8'h10, 8'h10, 0, 8'h00, 0, 0, 1, 0);

    // Start during RUN is ignored.
    A = 8'h50; B = 8'h30; BI = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    A = 8'h01; B = 8'h01; BI = 1; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(nb, seen);
    chk("ign_done", 32'(seen), 32'd1);
    chk("ign_busycyc", 32'(nb), 32'd5);
    chk("ign_Y", 32'(Y), 32'h20);
    chk("ign_C", 32'(C), 32'd0);

    // Back-to-back: start held in the done cycle.
    A = 8'h80; B = 8'h01; BI = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("b2b_acc", {30'd0, busy, done}, 32'b10);
    chk("b2b_hold", 32'(Y), 32'h20);
    wait_done(nb, seen);
    chk("b2b_done", 32'(seen), 32'd1);
    chk("b2b_busycyc", 32'(nb), 32'd8);
    chk("b2b_Y", 32'(Y), 32'h7F);
    chk("b2b_V", 32'(V), 32'd1);
    @(negedge clk);

    // Reset on the edge processing bit 4.
    A = 8'h7F; B = 8'hFF; BI = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("mid_rst", {19'd0, busy, done, Y, C, V, Z, N}, 32'd0);
    reset_n = 1;
    any_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("no_done", 32'(any_done), 32'd0);
    do_op("fresh", 8'h30, 8'h50, 0, 8'hE0, 1, 0, 0, 1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
